// File: rtl/fetch_basic_if.sv
// Fetch-stage bundle: instruction-memory request/response channels, the
// F->D channel towards decode, and the squash/redirect input.
interface fetch_basic_if #(
    parameter int unsigned p_addr_bits = 32,
    parameter int unsigned p_inst_bits = 32
);
    logic                   mem_req_val;
    logic                   mem_req_rdy;
    logic [p_addr_bits-1:0] mem_req_addr;

    logic                   mem_resp_val;
    logic                   mem_resp_rdy;
    logic [p_inst_bits-1:0] mem_resp_data;

    logic                   D_val;
    logic                   D_rdy;
    logic [p_inst_bits-1:0] D_inst;
    logic [p_addr_bits-1:0] D_pc;

    logic                   squash_val;
    logic [p_addr_bits-1:0] squash_target;

    // Fetch stage side.
    modport master (
        output mem_req_val, mem_req_addr, mem_resp_rdy, D_val, D_inst, D_pc,
        input  mem_req_rdy, mem_resp_val, mem_resp_data, D_rdy, squash_val, squash_target
    );

    // Environment side: memory, decode and the redirecting stage.
    modport slave (
        input  mem_req_val, mem_req_addr, mem_resp_rdy, D_val, D_inst, D_pc,
        output mem_req_rdy, mem_resp_val, mem_resp_data, D_rdy, squash_val, squash_target
    );
endinterface

// File: rtl/fetch_basic.sv
// In-order single-issue fetch stage. Owns the PC, keeps up to p_max_in_flight
// memory reads outstanding, pairs each response with its PC from a small FIFO
// and passes it straight through to decode. A squash redirects the PC and
// marks every outstanding request for silent discard.
module fetch_basic #(
    parameter int unsigned            p_addr_bits     = 32,
    parameter int unsigned            p_inst_bits     = 32,
    parameter logic [p_addr_bits-1:0] p_reset_addr    = 'h200,
    parameter int unsigned            p_max_in_flight = 2
) (
    input logic           clk,
    input logic           rst,
    fetch_basic_if.master bus_io
);

    localparam int unsigned CntW = $clog2(p_max_in_flight) + 1;
    localparam int unsigned PtrW = (p_max_in_flight > 1) ? $clog2(p_max_in_flight) : 1;

    typedef logic [CntW-1:0]        cnt_t;
    typedef logic [PtrW-1:0]        ptr_t;
    typedef logic [p_addr_bits-1:0] addr_t;

    localparam cnt_t MaxInFlight = cnt_t'(p_max_in_flight);
    localparam ptr_t LastPtr     = ptr_t'(p_max_in_flight - 1);

    addr_t pc_q, pc_d;
    cnt_t  in_flight_q, in_flight_d;
    cnt_t  drop_cnt_q, drop_cnt_d;
    ptr_t  wr_ptr_q, wr_ptr_d;
    ptr_t  rd_ptr_q, rd_ptr_d;
    addr_t pc_fifo_q [p_max_in_flight];

    logic req_val;
    logic resp_rdy;
    logic live;
    logic req_xfer;
    logic resp_xfer;

    function automatic ptr_t ptr_next(input ptr_t p);
        if (p == LastPtr) begin
            return '0;
        end
        return p + ptr_t'(1);
    endfunction

    // Handshake decode. The request side depends only on local state and the
    // squash input, never on the response or decode channels.
    always_comb begin
        live      = (drop_cnt_q == '0) & ~bus_io.squash_val;
        req_val   = rst & (in_flight_q < MaxInFlight) & ~bus_io.squash_val;
        // Stale responses are always swallowed so the memory never blocks on them.
        resp_rdy  = rst & (live ? bus_io.D_rdy : 1'b1);
        req_xfer  = req_val & bus_io.mem_req_rdy;
        resp_xfer = bus_io.mem_resp_val & resp_rdy;
    end

    assign bus_io.mem_req_val  = req_val;
    assign bus_io.mem_req_addr = pc_q;
    assign bus_io.mem_resp_rdy = resp_rdy;
    assign bus_io.D_val        = rst & bus_io.mem_resp_val & live;
    assign bus_io.D_inst       = bus_io.mem_resp_data;
    assign bus_io.D_pc         = pc_fifo_q[rd_ptr_q];

    // Next-state for PC, occupancy, discard counter and FIFO pointers.
    always_comb begin
        pc_d        = pc_q;
        in_flight_d = in_flight_q + cnt_t'(req_xfer) - cnt_t'(resp_xfer);
        drop_cnt_d  = drop_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;

        if (req_xfer) begin
            pc_d     = pc_q + addr_t'(4);
            wr_ptr_d = ptr_next(wr_ptr_q);
        end
        if (resp_xfer) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end

        if (bus_io.squash_val) begin
            // Everything still outstanding after this cycle belongs to the old path.
            pc_d       = bus_io.squash_target;
            drop_cnt_d = in_flight_q - cnt_t'(resp_xfer);
        end else if (resp_xfer && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - cnt_t'(1);
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q        <= p_reset_addr;
            in_flight_q <= '0;
            drop_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            pc_q        <= pc_d;
            in_flight_q <= in_flight_d;
            drop_cnt_q  <= drop_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // PC FIFO storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (req_xfer) begin
            pc_fifo_q[wr_ptr_q] <= pc_q;
        end
    end

    // A response with nothing outstanding means the memory invented a transaction.
    resp_has_owner: assert property (@(posedge clk) disable iff (!rst)
        bus_io.mem_resp_val |-> (in_flight_q != '0));

    in_flight_bounded: assert property (@(posedge clk) disable iff (!rst)
        (in_flight_q <= MaxInFlight) && (drop_cnt_q <= in_flight_q));

endmodule

// File: tb/tb_fetch_basic.sv
// Bench for fetch_basic: a variable-latency in-order memory model, a scoreboard
// of expected {pc, inst} pairs pushed when the memory accepts a request and
// popped when the response is consumed, and per-cycle handshake checks.
module tb_fetch_basic;

    localparam int unsigned MaxInFlight = 2;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } mem_ent_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        bit          drop;
    } sb_ent_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    fetch_basic_if #(.p_addr_bits(32), .p_inst_bits(32)) bus ();

    fetch_basic #(
        .p_addr_bits    (32),
        .p_inst_bits    (32),
        .p_reset_addr   (32'h200),
        .p_max_in_flight(MaxInFlight)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus_io(bus)
    );

    mem_ent_t    mem_q[$];
    sb_ent_t     sb_q[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned cyc      = 0;
    int unsigned n_deliv  = 0;
    logic [31:0] exp_pc   = 32'h200;
    logic [31:0] last_dpc = '0;
    bit          sq       = 1'b0;
    logic [31:0] sq_tgt   = '0;
    bit          d_rdy    = 1'b1;
    bit          rq_rdy   = 1'b1;
    int unsigned lat      = 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h want %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // One clock: drive at negedge, check just before posedge, update models after it.
    task automatic step();
        bit          req_x;
        bit          resp_x;
        bit          live;
        bit          exp_rv;
        logic [31:0] req_addr;
        sb_ent_t     e;

        @(negedge clk);
        bus.squash_val    = sq;
        bus.squash_target = sq_tgt;
        bus.D_rdy         = d_rdy;
        bus.mem_req_rdy   = rq_rdy;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            bus.mem_resp_val  = 1'b1;
            bus.mem_resp_data = mem_word(mem_q[0].addr);
        end else begin
            bus.mem_resp_val  = 1'b0;
            bus.mem_resp_data = $urandom;
        end

        #4;
        exp_rv = (mem_q.size() < MaxInFlight) && !sq;
        check_eq("req_val", 32'(bus.mem_req_val), 32'(exp_rv));
        if (bus.mem_req_val) begin
            check_eq("req_addr", bus.mem_req_addr, exp_pc);
        end
        live = !sq && !(sb_q.size() > 0 && sb_q[0].drop);
        check_eq("resp_rdy", 32'(bus.mem_resp_rdy), live ? 32'(d_rdy) : 32'd1);
        check_eq("d_val", 32'(bus.D_val), 32'(bus.mem_resp_val && live));
        if (bus.mem_resp_val && live && sb_q.size() > 0) begin
            check_eq("d_pc", bus.D_pc, sb_q[0].pc);
            check_eq("d_inst", bus.D_inst, sb_q[0].inst);
        end
        req_x    = bus.mem_req_val && bus.mem_req_rdy;
        req_addr = bus.mem_req_addr;
        resp_x   = bus.mem_resp_val && bus.mem_resp_rdy;

        @(posedge clk);
        cyc++;
        if (resp_x && mem_q.size() > 0) begin
            void'(mem_q.pop_front());
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if (!e.drop && !sq) begin
                    n_deliv++;
                    last_dpc = e.pc;
                end
            end
        end
        if (sq) begin
            foreach (sb_q[i]) sb_q[i].drop = 1'b1;
            exp_pc = sq_tgt;
        end
        if (req_x) begin
            mem_q.push_back('{addr: req_addr, due: cyc + lat - 1});
            sb_q.push_back('{pc: exp_pc, inst: mem_word(exp_pc), drop: 1'b0});
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic pulse_squash(input logic [31:0] tgt);
        sq     = 1'b1;
        sq_tgt = tgt;
        step();
        sq     = 1'b0;
    endtask

    // Step until the next instruction reaches decode, within a cycle budget.
    task automatic run_until_deliver(input string tag, input logic [31:0] exp);
        int unsigned start;
        int unsigned budget;
        start  = n_deliv;
        budget = 0;
        while (n_deliv == start && budget < 50) begin
            step();
            budget++;
        end
        check_eq({tag, "_seen"}, 32'(n_deliv != start), 32'd1);
        check_eq(tag, last_dpc, exp);
    endtask

    // Reset DUT and memory together; outputs must drop as soon as rst falls.
    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        check_eq("rst_req_val", 32'(bus.mem_req_val), 32'd0);
        check_eq("rst_d_val", 32'(bus.D_val), 32'd0);
        check_eq("rst_resp_rdy", 32'(bus.mem_resp_rdy), 32'd0);
        bus.mem_resp_val = 1'b0;
        bus.squash_val   = 1'b0;
        mem_q.delete();
        sb_q.delete();
        exp_pc = 32'h200;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        int unsigned n0;
        int unsigned guard;
        logic [31:0] p;

        bus.mem_req_rdy   = 1'b1;
        bus.mem_resp_val  = 1'b0;
        bus.mem_resp_data = '0;
        bus.D_rdy         = 1'b1;
        bus.squash_val    = 1'b0;
        bus.squash_target = '0;
        do_reset();

        // Single-cycle memory: one instruction per cycle after the first.
        lat = 1;
        n0  = n_deliv;
        repeat (20) step();
        check_eq("lat1_count", n_deliv - n0, 32'd19);
        check_eq("lat1_last_pc", last_dpc, 32'h248);

        // Three-cycle memory: requests must cap at two outstanding.
        lat = 3;
        repeat (30) step();

        // Decode stall mid-stream.
        lat = 1;
        repeat (5) step();
        p     = last_dpc;
        d_rdy = 1'b0;
        n0    = n_deliv;
        repeat (5) step();
        check_eq("stall_no_deliv", n_deliv - n0, 32'd0);
        d_rdy = 1'b1;
        run_until_deliver("stall_resume", p + 32'd4);

        // Squash with two requests outstanding.
        lat   = 3;
        guard = 0;
        while (mem_q.size() != 2 && guard < 20) begin
            step();
            guard++;
        end
        check_eq("two_in_flight", mem_q.size(), 32'd2);
        pulse_squash(32'h400);
        run_until_deliver("sq400", 32'h400);
        run_until_deliver("sq404", 32'h404);

        // Squash alongside a response transfer, then a second squash right after.
        lat = 1;
        repeat (4) step();
        sq     = 1'b1;
        sq_tgt = 32'h400;
        step();
        sq_tgt = 32'h500;
        step();
        sq     = 1'b0;
        run_until_deliver("sq500", 32'h500);
        run_until_deliver("sq504", 32'h504);

        // PC wraps at the top of the address space.
        pulse_squash(32'hffff_fff8);
        run_until_deliver("wrap_a", 32'hffff_fff8);
        run_until_deliver("wrap_b", 32'hffff_fffc);
        run_until_deliver("wrap_0", 32'h0000_0000);

        // Random mix of latency, backpressure and squashes.
        for (int i = 0; i < 300; i++) begin
            lat    = $urandom_range(1, 4);
            rq_rdy = ($urandom_range(0, 3) != 0);
            d_rdy  = ($urandom_range(0, 3) != 0);
            sq     = ($urandom_range(0, 24) == 0);
            sq_tgt = $urandom & 32'hffff_fffc;
            step();
            sq = 1'b0;
        end

        // Reset with requests in flight.
        lat    = 3;
        rq_rdy = 1'b1;
        d_rdy  = 1'b1;
        repeat (4) step();
        do_reset();
        run_until_deliver("post_rst", 32'h200);
        run_until_deliver("post_rst_b", 32'h204);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
